dev_uart_tx_arb: RTL and testbench
==================================

# dev_uart_tx_arb

Round-robin transmit arbiter that shares the single byte-wide transmit port of the asynchronous UART device among N independent requesters. Each requester offers bytes over its own strobe/acknowledge handshake; the arbiter grants one requester and forwards that requester's byte to the UART `TX_STB`/`TX_DAT`/`TX_ACK`/`TX_RDY` port. It returns a per-requester acknowledge once the UART has accepted the byte. It sits between the tester's message sources (status reporter, command echo, data dump) and the UART device.

## Interface
- `N`, 4, number of requesters; legal range 2..8.
- `CLK` in 1: system clock; all logic on rising edge.
- `RST_N` in 1: asynchronous reset, active-low.
- `REQ_STB` in N: per-requester byte valid; held until the matching `REQ_ACK`.
- `REQ_DAT` in 8*N: byte of requester i on bits [8i+7:8i].
- `REQ_LAST` in N: marks the last byte of a packet; used only with the lock feature.
- `REQ_ACK` out N: one-cycle pulse when the byte of requester i has been accepted by the UART.
- `GRANT` out N: one-hot current grant; all zeros when idle.
- `BUSY` out 1: high in any state other than IDLE.
- `TX_STB` out 1: strobe to the UART transmit port.
- `TX_DAT` out 8: byte to the UART.
- `TX_ACK` in 1: UART accept acknowledge.
- `TX_RDY` in 1: UART ready; low while a byte is in flight.

## Operation
- FSM states:
  - IDLE: if any eligible `REQ_STB` is high, pick a winner, latch it into `GRANT`, latch its byte into `TX_DAT`, set `TX_STB`=1, and go to SEND.
  - SEND: hold `TX_STB`/`TX_DAT`. When `TX_ACK`=1 is sampled: `TX_STB`<=0, pulse `REQ_ACK[g]`, update the pointer to g, and go to WAIT.
  - WAIT: when `TX_RDY`=1 and `TX_ACK`=0, clear `GRANT` and go to IDLE. `GRANT` is kept instead of cleared when a lock is held.
- Round-robin arbitration: search from pointer+1 upward, modulo N. The first `REQ_STB` high wins. The pointer holds the last served index; it wraps from N-1 to 0.
- The byte is sampled once, at grant. A requester changing `REQ_DAT` after grant has no effect on the byte sent.
- A requester that drops `REQ_STB` after grant but before its ack is still served. The byte is sent and `REQ_ACK` still pulses.
- `REQ_STB` deasserted on all inputs: stay in IDLE; outputs stay at reset values except the pointer.
- At most one `REQ_ACK` bit is high in any cycle.

## Timing
- Reset values: `TX_STB`=0, `TX_DAT`=0x00, `REQ_ACK`=0, `GRANT`=0, `BUSY`=0, pointer=N-1 (requester 0 wins first), FSM=IDLE, lock cleared.
- `RST_N` low in any state returns to the reset values immediately. No `REQ_ACK` is generated for an aborted byte.
- Latency:
  - `REQ_STB` sampled high at edge k gives `TX_STB`=1 and valid `TX_DAT` after edge k.
  - `TX_ACK` sampled high at edge m gives `REQ_ACK` high for cycle m..m+1 and `TX_STB`=0 after edge m.
- IDLE is re-entered no earlier than edge m+1. The requester's ack-cycle update of `REQ_STB`/`REQ_DAT` is therefore visible at the next arbitration.
- If `TX_ACK` is held high across several cycles, only one `REQ_ACK` pulse is produced. The WAIT state absorbs the rest.
- Back-to-back throughput is limited only by UART `TX_RDY`.

## Configuration
- `UART_ARB_LOCK_EN` defined: packet lock.
  - After acking a byte with `REQ_LAST[g]`=0, the lock is set and `GRANT` stays on g through WAIT and IDLE.
  - While locked, only requester g is eligible and other requesters wait.
  - The lock clears after acking a byte with `REQ_LAST[g]`=1, and on reset.
- `UART_ARB_LOCK_EN` undefined: `REQ_LAST` is ignored, every byte is re-arbitrated, and the lock register is absent.

## Test plan
- Reset then single request: `REQ_STB[2]`=1 with 0x41. Required: `TX_DAT`=0x41, `GRANT`=0b0100, and `TX_STB` high one cycle later. UART ack then gives one `REQ_ACK[2]` pulse and `BUSY` low after `TX_RDY` returns.
- All four requesting continuously with bytes 0x10..0x13. Required: sent order 0x10, 0x11, 0x12, 0x13, 0x10, with no requester served twice in a row.
- Requester 1 changes `REQ_DAT` from 0x55 to 0xAA after grant. Required: 0x55 is sent; 0xAA goes out on the next grant to requester 1.
- `RST_N` pulsed low during SEND. Required: `TX_STB`=0, `GRANT`=0, no `REQ_ACK`; requester 0 wins the next arbitration.
- `UART_ARB_LOCK_EN`: requester 0 sends 3 bytes with `REQ_LAST`=0,0,1 while requester 1 requests. Required: 3 bytes from requester 0 are sent contiguously, then requester 1. Without the macro the sent order is 0, 1, 0, 1, 0.
- `TX_ACK` held high for 3 cycles. Required: exactly one `REQ_ACK` pulse, and the FSM waits in WAIT until `TX_ACK`=0 and `TX_RDY`=1.

Source files
------------

// File: rtl/dev_uart_tx_arb_if.sv
// Requester and UART transmit port bundle for dev_uart_tx_arb.
// The slave modport faces the arbiter. The master modport faces the requesters and the UART.
interface dev_uart_tx_arb_if #(
   parameter int unsigned N = 4
);
   logic [N-1:0]   req_stb;
   logic [8*N-1:0] req_dat;
   logic [N-1:0]   req_last;
   logic [N-1:0]   req_ack;
   logic [N-1:0]   grant;
   logic           busy;
   logic           tx_stb;
   logic [7:0]     tx_dat;
   logic           tx_ack;
   logic           tx_rdy;

   modport slave (
      input  req_stb, req_dat, req_last, tx_ack, tx_rdy,
      output req_ack, grant, busy, tx_stb, tx_dat
   );

   modport master (
      output req_stb, req_dat, req_last, tx_ack, tx_rdy,
      input  req_ack, grant, busy, tx_stb, tx_dat
   );
endinterface

// File: rtl/dev_uart_tx_arb.sv
// Round-robin arbiter sharing one byte-wide UART transmit port among N requesters.
// Optional packet lock is enabled by defining UART_ARB_LOCK_EN.
module dev_uart_tx_arb #(
   parameter int unsigned N = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   dev_uart_tx_arb_if.slave bus
);
   localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

   state_t        state, state_nxt;
   logic [PW-1:0] ptr, ptr_nxt;
   logic [PW-1:0] gidx, gidx_nxt;
   logic [PW-1:0] win_idx, cand;
   logic          win_found;
   logic [N-1:0]  eligible;
   logic [N-1:0]  grant, grant_nxt;
   logic [N-1:0]  req_ack, req_ack_nxt;
   logic          tx_stb, tx_stb_nxt;
   logic [7:0]    tx_dat, tx_dat_nxt;
   logic          busy, busy_nxt;
   logic          locked;

`ifdef UART_ARB_LOCK_EN
   logic lock, lock_nxt;
   assign locked = lock;
`else
   logic unused_last;
   assign locked      = 1'b0;
   assign unused_last = ^bus.req_last;
`endif

   // While a packet lock is held only the current owner may be picked.
   assign eligible = locked ? (bus.req_stb & grant) : bus.req_stb;

   // Round-robin search starting just after the last served index.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int unsigned i = 1; i <= N; i++) begin
         cand = PW'((32'(ptr) + i) % N);
         if (!win_found && eligible[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   always_comb begin
      state_nxt   = state;
      ptr_nxt     = ptr;
      gidx_nxt    = gidx;
      grant_nxt   = grant;
      req_ack_nxt = '0;
      tx_stb_nxt  = tx_stb;
      tx_dat_nxt  = tx_dat;
`ifdef UART_ARB_LOCK_EN
      lock_nxt    = lock;
`endif
      case (state)
         IDLE: begin
            if (win_found) begin
               grant_nxt  = N'(1) << win_idx;
               gidx_nxt   = win_idx;
               tx_dat_nxt = bus.req_dat[{win_idx, 3'b000} +: 8];
               tx_stb_nxt = 1'b1;
               state_nxt  = SEND;
            end
         end
         SEND: begin
            if (bus.tx_ack) begin
               tx_stb_nxt  = 1'b0;
               req_ack_nxt = grant;
               ptr_nxt     = gidx;
`ifdef UART_ARB_LOCK_EN
               lock_nxt    = ~bus.req_last[gidx];
`endif
               state_nxt   = WAIT;
            end
         end
         WAIT: begin
            // A held TX_ACK is absorbed here so only one REQ_ACK pulse results.
            if (bus.tx_rdy && !bus.tx_ack) begin
               if (!locked) grant_nxt = '0;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
      busy_nxt = (state_nxt != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         ptr     <= PW'(N - 1);
         gidx    <= '0;
         grant   <= '0;
         req_ack <= '0;
         tx_stb  <= 1'b0;
         tx_dat  <= 8'h00;
         busy    <= 1'b0;
`ifdef UART_ARB_LOCK_EN
         lock    <= 1'b0;
`endif
      end else begin
         state   <= state_nxt;
         ptr     <= ptr_nxt;
         gidx    <= gidx_nxt;
         grant   <= grant_nxt;
         req_ack <= req_ack_nxt;
         tx_stb  <= tx_stb_nxt;
         tx_dat  <= tx_dat_nxt;
         busy    <= busy_nxt;
`ifdef UART_ARB_LOCK_EN
         lock    <= lock_nxt;
`endif
      end
   end

   assign bus.grant   = grant;
   assign bus.req_ack = req_ack;
   assign bus.tx_stb  = tx_stb;
   assign bus.tx_dat  = tx_dat;
   assign bus.busy    = busy;
endmodule

// File: tb/tb_dev_uart_tx_arb.sv
// Self-checking bench for dev_uart_tx_arb: directed scenarios plus randomized traffic
// checked against a queue-based round-robin reference model.
module tb_dev_uart_tx_arb;
   localparam int unsigned N = 4;
`ifdef UART_ARB_LOCK_EN
   localparam bit LOCK_EN = 1'b1;
`else
   localparam bit LOCK_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;

   dev_uart_tx_arb_if #(.N(N)) bus ();
   dev_uart_tx_arb #(.N(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   // Per-requester pending byte queues; the head is what the requester offers.
   logic [7:0] qd [N][64];
   logic       ql [N][64];
   int         qh [N];
   int         qt [N];

   int m_ptr;
   int m_owner;
   bit m_lock;

   logic [7:0] sent_b [128];
   int         sent_w [128];
   int         n_sent;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic drive_req(input int i);
      if (qh[i] < qt[i]) begin
         bus.req_stb[i]         = 1'b1;
         bus.req_dat[8*i +: 8]  = qd[i][qh[i]];
         bus.req_last[i]        = ql[i][qh[i]];
      end else begin
         bus.req_stb[i] = 1'b0;
      end
   endtask

   task automatic push(input int i, input logic [7:0] b, input logic last);
      if (qt[i] < 64) begin
         qd[i][qt[i]] = b;
         ql[i][qt[i]] = last;
         qt[i]++;
      end
   endtask

   function automatic int model_pick();
      if (m_lock) return m_owner;
      for (int k = 1; k <= int'(N); k++) begin
         int c;
         c = (m_ptr + k) % int'(N);
         if (qh[c] < qt[c]) return c;
      end
      return -1;
   endfunction

   task automatic do_reset();
      bus.tx_ack   = 1'b0;
      bus.tx_rdy   = 1'b1;
      bus.req_stb  = '0;
      bus.req_dat  = '0;
      bus.req_last = '0;
      for (int i = 0; i < int'(N); i++) begin
         qh[i] = 0;
         qt[i] = 0;
      end
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      step();
      m_ptr   = int'(N) - 1;
      m_lock  = 1'b0;
      m_owner = 0;
   endtask

   // Requesters react to an observed REQ_ACK by offering their next byte (or dropping STB).
   task automatic note_ack(inout int acks, inout logic [N-1:0] bits);
      chk("req_ack_onehot0", 32'($onehot0(bus.req_ack)), 32'd1);
      if (bus.req_ack != '0) begin
         acks++;
         bits |= bus.req_ack;
         for (int i = 0; i < int'(N); i++) begin
            if (bus.req_ack[i]) begin
               if (qh[i] < qt[i]) qh[i]++;
               drive_req(i);
            end
         end
      end
   endtask

   // Acts as the UART for one byte: waits for TX_STB, acks for 'hold' cycles, then returns ready.
   task automatic serve(input int hold, input bit chk_lat, input bit rdy_hold);
      int         w;
      int         wn;
      int         acks;
      int         gw;
      logic [7:0] eb;
      logic       el;
      logic [N-1:0] bits;
      w = model_pick();
      if (w < 0) return;
      eb = qd[w][qh[w]];
      el = ql[w][qh[w]];
      wn = 0;
      while (!bus.tx_stb && wn < 50) begin
         step();
         wn++;
      end
      chk("tx_stb_rise", 32'(bus.tx_stb), 32'd1);
      if (chk_lat) chk("grant_latency", 32'(wn), 32'd1);
      chk("grant", 32'(bus.grant), 32'(1) << w);
      chk("tx_dat", 32'(bus.tx_dat), 32'(eb));
      chk("busy_send", 32'(bus.busy), 32'd1);
      gw = -1;
      for (int i = 0; i < int'(N); i++) if (bus.grant[i]) gw = i;
      if (n_sent < 128) begin
         sent_b[n_sent] = bus.tx_dat;
         sent_w[n_sent] = gw;
         n_sent++;
      end
      acks = 0;
      bits = '0;
      bus.tx_ack = 1'b1;
      bus.tx_rdy = rdy_hold;
      for (int j = 0; j < hold; j++) begin
         step();
         note_ack(acks, bits);
         chk("busy_ack_held", 32'(bus.busy), 32'd1);
         chk("tx_stb_drop", 32'(bus.tx_stb), 32'd0);
      end
      bus.tx_ack = 1'b0;
      bus.tx_rdy = 1'b0;
      step();
      note_ack(acks, bits);
      chk("busy_rdy_low", 32'(bus.busy), 32'd1);
      bus.tx_rdy = 1'b1;
      step();
      note_ack(acks, bits);
      chk("busy_idle", 32'(bus.busy), 32'd0);
      chk("req_ack_count", 32'(acks), 32'd1);
      chk("req_ack_bit", 32'(bits), 32'(1) << w);
      m_ptr   = w;
      m_lock  = LOCK_EN && !el;
      m_owner = w;
      chk("grant_after", 32'(bus.grant), m_lock ? (32'(1) << w) : 32'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] exp5 [5];
      int         ord_l [5];
      int         ord_u [5];
      int         g;
      exp5  = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
      ord_l = '{0, 0, 0, 1, 1};
      ord_u = '{0, 1, 0, 1, 0};
      n_sent = 0;
      rst_n  = 1'b0;

      // Reset values, then a single request from requester 2.
      do_reset();
      chk("rst_tx_stb", 32'(bus.tx_stb), 32'd0);
      chk("rst_tx_dat", 32'(bus.tx_dat), 32'd0);
      chk("rst_req_ack", 32'(bus.req_ack), 32'd0);
      chk("rst_grant", 32'(bus.grant), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      push(2, 8'h41, 1'b1);
      drive_req(2);
      serve(1, 1'b1, 1'b0);

      // All four requesting continuously.
      do_reset();
      n_sent = 0;
      for (int i = 0; i < int'(N); i++) begin
         push(i, 8'(8'h10 + i), 1'b1);
         push(i, 8'(8'h10 + i), 1'b1);
         drive_req(i);
      end
      g = 0;
      while (model_pick() >= 0 && g < 20) begin
         serve(1, 1'b1, 1'b0);
         g++;
      end
      for (int k = 0; k < 5; k++) chk("rr_order", 32'(sent_b[k]), 32'(exp5[k]));

      // Byte sampled at grant; requester changes data and drops STB afterwards.
      do_reset();
      push(1, 8'h55, 1'b1);
      push(1, 8'hAA, 1'b1);
      drive_req(1);
      step();
      chk("hold_stb", 32'(bus.tx_stb), 32'd1);
      chk("hold_dat0", 32'(bus.tx_dat), 32'h55);
      bus.req_dat[15:8] = 8'hAA;
      bus.req_stb[1]    = 1'b0;
      step();
      chk("hold_dat1", 32'(bus.tx_dat), 32'h55);
      serve(1, 1'b0, 1'b0);
      serve(2, 1'b1, 1'b1);

      // Reset asserted during SEND.
      do_reset();
      push(2, 8'h77, 1'b1);
      drive_req(2);
      step();
      chk("pre_rst_stb", 32'(bus.tx_stb), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("abort_tx_stb", 32'(bus.tx_stb), 32'd0);
      chk("abort_grant", 32'(bus.grant), 32'd0);
      chk("abort_req_ack", 32'(bus.req_ack), 32'd0);
      chk("abort_busy", 32'(bus.busy), 32'd0);
      #1;
      rst_n   = 1'b1;
      m_ptr   = int'(N) - 1;
      m_lock  = 1'b0;
      push(0, 8'h99, 1'b1);
      drive_req(0);
      serve(1, 1'b1, 1'b0);
      serve(1, 1'b1, 1'b0);

      // Packet of three bytes from requester 0 competing with requester 1.
      do_reset();
      n_sent = 0;
      push(0, 8'hA0, 1'b0);
      push(0, 8'hA1, 1'b0);
      push(0, 8'hA2, 1'b1);
      push(1, 8'hB0, 1'b1);
      push(1, 8'hB1, 1'b1);
      drive_req(0);
      drive_req(1);
      g = 0;
      while (model_pick() >= 0 && g < 20) begin
         serve(1, 1'b1, 1'b0);
         g++;
      end
      for (int k = 0; k < 5; k++)
         chk("lock_order", 32'(sent_w[k]), 32'(LOCK_EN ? ord_l[k] : ord_u[k]));

      // TX_ACK held for three cycles with TX_RDY high.
      do_reset();
      push(3, 8'h5A, 1'b1);
      drive_req(3);
      serve(3, 1'b1, 1'b1);

      // Randomized traffic against the reference model.
      do_reset();
      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < int'(N); i++) begin
            int nb;
            nb = int'($urandom_range(0, 3));
            for (int b = 0; b < nb; b++)
               push(i, 8'($urandom), (b == nb - 1) ? 1'b1 : 1'($urandom_range(0, 1)));
            drive_req(i);
         end
         g = 0;
         while (model_pick() >= 0 && g < 100) begin
            serve(int'($urandom_range(1, 3)), 1'b1, 1'($urandom_range(0, 1)));
            g++;
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
